seven_segment_scan_driver: RTL and testbench

//  Parametrised, time-multiplexed driver for an N-digit common-anode 7-seg display.

---
 rtl/seven_segment_scan_driver_pkg.sv | 53 +++++
 rtl/seven_segment_scan_driver_digit_lut.sv | 14 +
 rtl/seven_segment_scan_driver.sv | 131 +++++++++++++
 tb/tb_seven_segment_scan_driver.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_scan_driver_pkg.sv
// Shared seven-segment definitions: segment encodings, blank/all-on patterns
// and the nibble-to-segment encoder used by the scan driver and any future decoder.
package seven_segment_scan_driver_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_t;

    // Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
    localparam seg_t SEG_BLANK  = 7'h00;
    localparam seg_t SEG_ALL_ON = 7'h7F;

    localparam seg_t SEG_HEX_0 = 7'h3F;
    localparam seg_t SEG_HEX_1 = 7'h06;
    localparam seg_t SEG_HEX_2 = 7'h5B;
    localparam seg_t SEG_HEX_3 = 7'h4F;
    localparam seg_t SEG_HEX_4 = 7'h66;
    localparam seg_t SEG_HEX_5 = 7'h6D;
    localparam seg_t SEG_HEX_6 = 7'h7D;
    localparam seg_t SEG_HEX_7 = 7'h07;
    localparam seg_t SEG_HEX_8 = 7'h7F;
    localparam seg_t SEG_HEX_9 = 7'h67;
    localparam seg_t SEG_HEX_A = 7'h77;
    localparam seg_t SEG_HEX_B = 7'h7C;
    localparam seg_t SEG_HEX_C = 7'h39;
    localparam seg_t SEG_HEX_D = 7'h5E;
    localparam seg_t SEG_HEX_E = 7'h79;
    localparam seg_t SEG_HEX_F = 7'h71;

    function automatic seg_t seg_encode(input nibble_t nib);
        seg_t s;
        case (nib)
            4'h0:    s = SEG_HEX_0;
            4'h1:    s = SEG_HEX_1;
            4'h2:    s = SEG_HEX_2;
            4'h3:    s = SEG_HEX_3;
            4'h4:    s = SEG_HEX_4;
            4'h5:    s = SEG_HEX_5;
            4'h6:    s = SEG_HEX_6;
            4'h7:    s = SEG_HEX_7;
            4'h8:    s = SEG_HEX_8;
            4'h9:    s = SEG_HEX_9;
            4'hA:    s = SEG_HEX_A;
            4'hB:    s = SEG_HEX_B;
            4'hC:    s = SEG_HEX_C;
            4'hD:    s = SEG_HEX_D;
            4'hE:    s = SEG_HEX_E;
            4'hF:    s = SEG_HEX_F;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_segment_scan_driver_digit_lut.sv
// Combinational hex nibble to active-high {g..a} segment pattern.
module seven_segment_digit_lut
    import seven_segment_scan_driver_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Pure table lookup; polarity is applied by the caller.
    always_comb begin
        o_seg = seg_encode(i_nibble);
    end

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed N-digit seven-segment scan driver with double-buffered value.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_segment_scan_driver
    import seven_segment_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    enable,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? SEG_ALL_ON : SEG_BLANK;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [CNT_W-1:0]        r_count;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_active;
    logic                    r_frame;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;

    logic                    w_tick;
    logic                    w_boundary;
    logic [3:0]              w_nibble;
    logic [6:0]              w_seg_ah;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [NUM_DIGITS-1:0]   w_lit;
    logic                    w_digit_lit;
    logic [6:0]              w_seg_drive;
    logic [NUM_DIGITS-1:0]   w_an_drive;

    assign w_tick      = enable & (r_count == CNT_LAST);
    assign w_boundary  = w_tick & (r_idx == IDX_LAST);
    assign w_nibble    = 4'(r_active >> {r_idx, 2'b00});
    assign w_onehot    = NUM_DIGITS'(1'b1) << r_idx;
    assign w_digit_lit = |(w_lit & w_onehot);

    seven_segment_digit_lut u_lut (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_ah)
    );

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    // Digit i stays lit only if it or some more-significant nibble is non-zero.
    always_comb begin
        w_lit = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            w_lit[i] = |(r_active >> (4 * i));
        end
        w_lit[0] = 1'b1;
    end
`else
    // Every digit is shown, zeros included.
    always_comb begin
        w_lit = {NUM_DIGITS{1'b1}};
    end
`endif

    // Board polarity applied to the lit-digit patterns.
    always_comb begin
        if (ACTIVE_LOW != 0) begin
            w_seg_drive = ~w_seg_ah;
            w_an_drive  = ~w_onehot;
        end else begin
            w_seg_drive = w_seg_ah;
            w_an_drive  = w_onehot;
        end
    end

    // Prescaler and digit index; both freeze while the scan is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_idx   <= '0;
        end else if (w_tick) begin
            r_count <= '0;
            r_idx   <= w_boundary ? '0 : r_idx + IDX_W'(1'b1);
        end else if (enable) begin
            r_count <= r_count + CNT_W'(1'b1);
        end
    end

    // Double buffer: active only changes on a frame boundary, with load bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_active <= '0;
            r_frame  <= 1'b0;
        end else begin
            if (load) begin
                r_shadow <= value;
            end
            if (w_boundary) begin
                r_active <= load ? value : r_shadow;
            end
            r_frame <= w_boundary;
        end
    end

    // Registered pin drivers; dark when disabled or when the digit is blanked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
        end else if (enable && w_digit_lit) begin
            r_an  <= w_an_drive;
            r_seg <= w_seg_drive;
        end else begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
        end
    end

    assign seg   = r_seg;
    assign an    = r_an;
    assign frame = r_frame;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Scoreboard bench for seven_segment_scan_driver (NUM_DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1).
module tb_seven_segment_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        enable;
    logic [15:0] value;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [10:0] dq[$];
    int          fq[$];

    localparam logic [6:0] ENC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    seven_segment_scan_driver #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4),
        .ACTIVE_LOW (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .value  (value),
        .load   (load),
        .enable (enable),
        .seg    (seg),
        .an     (an),
        .frame  (frame)
    );

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expected {an,seg} for each of the four slots of a frame showing v.
    function automatic void push_frame(input logic [15:0] v);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] nib;
            logic       lit;
            nib = v[4*i +: 4];
            lit = 1'b1;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
            if (i > 0 && (v >> (4 * i)) == 16'h0000) lit = 1'b0;
`endif
            if (lit) dq.push_back({~(4'b0001 << i), ~ENC[nib]});
            else     dq.push_back({4'hF, 7'h7F});
        end
    endfunction

    task automatic wait_cyc(input int k);
        int n;
        n = 0;
        while (cyc < k && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc: timeout waiting for cyc %0d, at %0d", k, cyc);
        end
    endtask

    task automatic load_at(input int k, input logic [15:0] v);
        wait_cyc(k);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Monitor: each frame pulse is matched to its expected cycle, then the four
    // slots of that frame are sampled mid-slot and compared with the queue.
    initial begin
        logic [10:0] e;
        int          fe;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && frame === 1'b1) begin
                if (fq.size() == 0) begin
                    check("frame_unexpected", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    fe = fq.pop_front();
                    check("frame_cycle", 32'(cyc), 32'(fe));
                end
                if (dq.size() >= 4) begin
                    for (int j = 0; j < 4; j++) begin
                        repeat ((j == 0) ? 2 : 4) @(negedge clk);
                        e = dq.pop_front();
                        check($sformatf("slot%0d_an_seg", j), {21'd0, an, seg}, {21'd0, e});
                    end
                end
            end
        end
    end

    initial begin
        rst    = 1'b1;
        load   = 1'b0;
        enable = 1'b1;
        value  = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_an",    {28'd0, an},    32'hF);
        check("reset_seg",   {25'd0, seg},   32'h7F);
        check("reset_frame", {31'd0, frame}, 32'h0);

        push_frame(16'h1234);
        push_frame(16'hABCD);
        push_frame(16'h3210);
        push_frame(16'h7654);
        push_frame(16'hBA98);
        push_frame(16'hFEDC);
        push_frame(16'h0050);
        push_frame(16'h0000);
        for (int f = 1; f <= 9; f++) fq.push_back(16 * f);
        fq.push_back(167);

        rst = 1'b0;
        load_at(2, 16'h1234);
        wait_cyc(4);
        check("first_slot_an", {28'd0, an}, 32'hE);
        check("first_slot_seg", {25'd0, seg}, 32'h40);
        wait_cyc(5);
        check("first_tick_an", {28'd0, an}, 32'hD);
        wait_cyc(17);
        check("frame_width", {31'd0, frame}, 32'h0);

        load_at(25,  16'hABCD);
        load_at(47,  16'h3210);
        load_at(63,  16'h7654);
        load_at(79,  16'hBA98);
        load_at(95,  16'hFEDC);
        load_at(111, 16'h0050);
        load_at(127, 16'h0000);
        load_at(143, 16'h9876);

        wait_cyc(153);
        enable = 1'b0;
        wait_cyc(154);
        check("dark_an",  {28'd0, an},  32'hF);
        check("dark_seg", {25'd0, seg}, 32'h7F);
        wait_cyc(159);
        check("dark_hold_an", {28'd0, an}, 32'hF);
        wait_cyc(160);
        check("frozen_frame", {31'd0, frame}, 32'h0);
        enable = 1'b1;
        wait_cyc(161);
        check("resume_an",  {28'd0, an},  32'hB);
        check("resume_seg", {25'd0, seg}, 32'h00);
        wait_cyc(163);
        check("resume_hold_an", {28'd0, an}, 32'hB);
        wait_cyc(164);
        check("resume_next_an",  {28'd0, an},  32'h7);
        check("resume_next_seg", {25'd0, seg}, 32'h18);

        wait_cyc(170);
        check("frames_pending", 32'(fq.size()), 32'd0);
        check("slots_pending",  32'(dq.size()), 32'd0);

        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midreset_an",    {28'd0, an},    32'hF);
        check("midreset_seg",   {25'd0, seg},   32'h7F);
        check("midreset_frame", {31'd0, frame}, 32'h0);
        fq.push_back(16);
        repeat (3) @(negedge clk);
        check("reset_hold_an",  {28'd0, an},  32'hF);
        check("reset_hold_seg", {25'd0, seg}, 32'h7F);
        rst = 1'b0;
        wait_cyc(1);
        check("restart_an",  {28'd0, an},  32'hE);
        check("restart_seg", {25'd0, seg}, 32'h40);
        wait_cyc(4);
        check("restart_slot0_an", {28'd0, an}, 32'hE);
        wait_cyc(20);
        check("restart_frames_pending", 32'(fq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
